// File: rtl/cpu_eu_gen.sv
// Parametrised execution unit: register file, ALU, PC, IR, flags and address mux.
// Define CPU_EU_GEN_R0_ZERO_EN to hard-wire reg[0] to zero.

module cpu_eu_gen_reg #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);
  always_ff @(posedge clk or negedge reset)
    if (!reset)  q <= '0;
    else if (we) q <= d;
endmodule

module cpu_eu_gen #(
  parameter int DW = 16,
  parameter int RA = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] din,
  input  logic          adr_sel,
  input  logic          s_sel,
  input  logic          reg_w_en,
  input  logic          flag_ld,
  input  logic          ir_ld,
  input  logic          pc_ld,
  input  logic          pc_rel,
  input  logic          pc_inc,
  output logic [DW-1:0] address,
  output logic [DW-1:0] dout,
  output logic [DW-1:0] ir_out,
  output logic          n,
  output logic          z,
  output logic          c,
  output logic          v
);
  localparam int NREG = 1 << RA;
  localparam int MSB  = DW - 1;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  logic [DW-1:0]            ir, pc;
  logic [NREG-1:0][DW-1:0]  rf;
  logic [3:0]               op;
  logic [RA-1:0]            w_idx, r_idx, s_idx;
  logic [DW-1:0]            a, b, res;
  logic                     cy, ov;
  flags_t                   flg, flg_nxt;

  assign op    = ir[DW-1:DW-4];
  assign w_idx = ir[3*RA-1:2*RA];
  assign r_idx = ir[2*RA-1:RA];
  assign s_idx = ir[RA-1:0];

  assign a = rf[r_idx];
  assign b = s_sel ? din : rf[s_idx];

  // Register file: one clocked cell per entry, combinational read via rf.
  for (genvar g = 0; g < NREG; g++) begin : g_rf
`ifdef CPU_EU_GEN_R0_ZERO_EN
    if (g == 0) begin : g_zero
      assign rf[g] = '0;
    end else begin : g_cell
      cpu_eu_gen_reg #(.DW(DW)) u_reg (
        .clk   (clk),
        .reset (reset),
        .we    (reg_w_en && (w_idx == RA'(g))),
        .d     (res),
        .q     (rf[g])
      );
    end
`else
    cpu_eu_gen_reg #(.DW(DW)) u_reg (
      .clk   (clk),
      .reset (reset),
      .we    (reg_w_en && (w_idx == RA'(g))),
      .d     (res),
      .q     (rf[g])
    );
`endif
  end

  // ALU; carry on sub/dec is the unsigned borrow taken from bit DW.
  always_comb begin
    res = '0;
    cy  = 1'b0;
    ov  = 1'b0;
    case (op)
      4'h0: res = a;
      4'h1: res = b;
      4'h2: begin
        {cy, res} = {1'b0, a} + {1'b0, b};
        ov = (a[MSB] == b[MSB]) && (res[MSB] != a[MSB]);
      end
      4'h3: begin
        {cy, res} = {1'b0, a} - {1'b0, b};
        ov = (a[MSB] != b[MSB]) && (res[MSB] != a[MSB]);
      end
      4'h4: begin
        {cy, res} = {1'b0, a} + (DW+1)'(1);
        ov = !a[MSB] && res[MSB];
      end
      4'h5: begin
        {cy, res} = {1'b0, a} - (DW+1)'(1);
        ov = a[MSB] && !res[MSB];
      end
      4'h6: res = a & b;
      4'h7: res = a | b;
      4'h8: res = a ^ b;
      4'h9: res = ~a;
      4'hA: begin res = {a[DW-2:0], 1'b0};     cy = a[MSB]; end
      4'hB: begin res = {1'b0, a[DW-1:1]};     cy = a[0];   end
      4'hC: begin res = {a[MSB], a[DW-1:1]};   cy = a[0];   end
      4'hD: begin res = {a[DW-2:0], a[MSB]};   cy = a[MSB]; end
      4'hE: begin res = {a[0], a[DW-1:1]};     cy = a[0];   end
      default: res = '0;
    endcase
  end

  assign dout    = res;
  assign address = adr_sel ? a : pc;
  assign ir_out  = ir;

  assign flg_nxt = '{n: res[MSB], z: (res == '0), c: cy, v: ov};

  always_ff @(posedge clk or negedge reset)
    if (!reset)       flg <= '0;
    else if (flag_ld) flg <= flg_nxt;

  always_ff @(posedge clk or negedge reset)
    if (!reset)     ir <= '0;
    else if (ir_ld) ir <= din;

  always_ff @(posedge clk or negedge reset)
    if (!reset)       pc <= '0;
    else if (pc_ld)   pc <= dout;
    else if (pc_rel)  pc <= pc + {{(DW-8){ir[7]}}, ir[7:0]};
    else if (pc_inc)  pc <= pc + DW'(1);

  assign n = flg.n;
  assign z = flg.z;
  assign c = flg.c;
  assign v = flg.v;
endmodule

// File: doc/cpu_eu_gen.md
# cpu_eu_gen

Parametrised CPU execution unit: register file, ALU, program counter, instruction register, registered status flags and memory-address mux, all driven cycle by cycle by an external control unit. It is the width- and depth-generic successor of the 16-bit, 8-register execution unit. It adds a PC-relative branch path, an overflow flag and explicit flag-load control. It sits between the control FSM, which drives the strobes and decodes `ir_out`, and the memory, which drives `din` and receives `address`/`dout`.

## Interface
- `DW`, 16: data, address, PC and IR width; must satisfy `DW >= 3*RA + 4` and `DW >= 8`.
- `RA`, 3: register address bits; register count is 2^RA.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `din`  in  DW  memory read data; IR load source and S-operand alternative.
- `adr_sel`  in  1  1: `address` = reg[R]; 0: `address` = PC.
- `s_sel`  in  1  1: S operand = `din`; 0: S operand = reg[S].
- `reg_w_en`  in  1  write ALU result to reg[W] at the clock edge.
- `flag_ld`  in  1  load n/z/c/v from the current ALU result at the clock edge.
- `ir_ld`  in  1  IR <= `din`.
- `pc_ld`  in  1  PC <= `dout`.
- `pc_rel`  in  1  PC <= PC + sign-extended IR[7:0].
- `pc_inc`  in  1  PC <= PC + 1.
- `address`  out  DW  memory address.
- `dout`  out  DW  combinational ALU result.
- `ir_out`  out  DW  IR contents, for decode.
- `n`, `z`, `c`, `v`  out  1 each  registered negative, zero, carry/borrow and signed-overflow flags.

## Operation
- IR fields:
  - op = IR[DW-1:DW-4]
  - W = IR[3RA-1:2RA]
  - R = IR[2RA-1:RA]
  - S = IR[RA-1:0]
- ALU ops. A is reg[R]; B is the S operand.
  - 0 A; 1 B; 2 A+B; 3 A-B; 4 A+1; 5 A-1
  - 6 A&B; 7 A|B; 8 A^B; 9 ~A
  - A shl A; B shr A (logical); C asr A; D rol A; E ror A; F zero.
- Carry:
  - add and inc: carry-out.
  - sub and dec: 1 on unsigned borrow.
  - shifts and rotates: the bit shifted or rotated out.
  - all other ops: 0.
- v: two's-complement overflow for ops 2-5, else 0.
- n = `dout[DW-1]`; z = (`dout` == 0).
- PC update priority: `pc_ld` > `pc_rel` > `pc_inc` > hold.
  - PC arithmetic is modulo 2^DW; wraps from 2^DW-1 to 0 without error.
- Register file: 2^RA x DW. Reads are combinational. One write port, clocked.

## Timing
- Reset (`reset`=0), taking effect immediately without a clock edge:
  - PC, IR, all registers and n/z/c/v clear to 0.
  - `address` = 0, `ir_out` = 0, `dout` = 0 (op 0 on reg[0] = 0).
  - Reset asserted mid-operation discards all pending strobes.
- All state updates on the rising `clk` edge. Outputs settle combinationally from current state.
- Register write latency 1 cycle: a write to reg[k] is visible on reads in the following cycle. A same-cycle read returns the old value.
- Simultaneous strobes in one cycle:
  - `ir_ld` with `reg_w_en`/`flag_ld`/`pc_ld`: all use the old IR fields and old operands. The new IR takes effect next cycle.
  - `pc_ld` with `adr_sel`=0: `address` shows the old PC this cycle.
- `flag_ld`=0: flags hold, regardless of `reg_w_en`.

## Configuration
- `CPU_EU_GEN_R0_ZERO_EN` defined:
  - reg[0] is hard-wired to 0; writes to W=0 are dropped.
  - `flag_ld` still loads flags from that cycle's ALU result.
- Undefined: reg[0] is an ordinary register.

## Test plan
- Async reset: load PC=0x0023 and R1=0x5555, then drop `reset` between clock edges -> `address`, `dout`, `ir_out`, n/z/c/v are all 0 before the next edge; R1 reads 0 after release.
- Load and add overflow (DW=16, RA=3):
  - IR=0x1040, `s_sel`=1, `din`=0x7FFF, `reg_w_en` -> R1=0x7FFF.
  - IR=0x2089, `reg_w_en`+`flag_ld` -> R2=0xFFFE, n=1, z=0, c=0, v=1.
- Subtract borrow: R=0x0001, S=0x0002, op 3, `flag_ld` -> `dout`=0xFFFF, n=1, c=1, v=0. Then op B on 0x0001 -> `dout`=0x0000, z=1, c=1.
- PC priority and wrap:
  - `pc_ld`+`pc_rel`+`pc_inc` with `dout`=0x0100 -> PC=0x0100.
  - PC=0x0010 with IR[7:0]=0xFE, `pc_rel` -> 0x000E.
  - PC=0xFFFF, `pc_inc` -> 0x0000.
- Same-cycle hazards:
  - `ir_ld` + `reg_w_en` -> the write targets the old W.
  - Write R3 while `adr_sel`=1 with R=3 -> `address` shows the old value that cycle and the new value the next cycle.
- Macro: write 0x1234 to W=0, then `adr_sel`=1 with R=0 -> `address`=0x0000 with `CPU_EU_GEN_R0_ZERO_EN`, 0x1234 without.
